// File: rtl/bar_level_writer.sv
// Spectrum bar level writer: peak-holds per-band levels from magnitude samples,
// commits them to an 18-segment thermometer display shadow on each frame_sync, then decays.
module bar_level_writer #(
  parameter int SHIFT        = 11,
  parameter int DECAY_FRAMES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mag_valid,
  output logic         mag_ready,
  input  logic [3:0]   mag_band,
  input  logic [15:0]  mag_data,
  input  logic         frame_sync,
  output logic [287:0] bars,
  output logic         frame_done,
  output logic         sync_overrun
);

  localparam int FW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
  localparam logic [FW-1:0] FCNT_LAST = FW'(DECAY_FRAMES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    COMMIT = 2'd1,
    DECAY  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [4:0]    working [16];
  logic [3:0]    band_cnt;
  logic [FW-1:0] fcnt;
  logic          decay_due;
  logic [15:0]   shifted;
  logic [4:0]    new_level;
  logic          accept;
  logic [287:0]  commit_bars;

  function automatic logic [17:0] thermo(input logic [4:0] lvl);
    logic [17:0] t;
    for (int i = 0; i < 18; i++) begin
      t[i] = (5'(i) < lvl);
    end
    return t;
  endfunction

  // Saturating level quantiser and handshake qualifier
  always_comb begin
    shifted   = mag_data >> SHIFT;
    if (shifted > 16'd18) begin
      new_level = 5'd18;
    end else begin
      new_level = shifted[4:0];
    end
    accept       = mag_valid && mag_ready;
    mag_ready    = (state == RUN);
    sync_overrun = frame_sync && (state != RUN);
  end

  // Thermometer encoding of all working levels for the commit
  always_comb begin
    commit_bars = '0;
    for (int n = 0; n < 16; n++) begin
      commit_bars[18*n +: 18] = thermo(working[n]);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (frame_sync) begin
          state_next = COMMIT;
        end else begin
          state_next = RUN;
        end
      end
      COMMIT: state_next = DECAY;
      DECAY: begin
        if (band_cnt == 4'd15) begin
          state_next = RUN;
        end else begin
          state_next = DECAY;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Working levels, shadow (bars), frame counter and decay sweep
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < 16; n++) begin
        working[n] <= 5'd0;
      end
      bars       <= '0;
      frame_done <= 1'b0;
      fcnt       <= '0;
      decay_due  <= 1'b0;
      band_cnt   <= 4'd0;
    end else begin
      frame_done <= 1'b0;
      if (accept && (new_level > working[mag_band])) begin
        working[mag_band] <= new_level;
      end
      case (state)
        COMMIT: begin
          bars       <= commit_bars;
          frame_done <= 1'b1;
          decay_due  <= (fcnt == FCNT_LAST);
          fcnt       <= (fcnt == FCNT_LAST) ? '0 : fcnt + 1'b1;
          band_cnt   <= 4'd0;
        end
        DECAY: begin
          // Shadow stays frozen here; decayed levels surface at the next commit
          if (decay_due && (working[band_cnt] != 5'd0)) begin
            working[band_cnt] <= working[band_cnt] - 5'd1;
          end
          band_cnt <= band_cnt + 4'd1;
        end
        default: begin
          band_cnt <= band_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bar_level_writer.sv
// Randomised self-checking bench for bar_level_writer against a frame-level model.
module tb_bar_level_writer;

  localparam int SHIFT = 11;
  localparam int DF    = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         mag_valid = 1'b0;
  logic         mag_ready;
  logic [3:0]   mag_band = 4'd0;
  logic [15:0]  mag_data = 16'd0;
  logic         frame_sync = 1'b0;
  logic [287:0] bars;
  logic         frame_done;
  logic         sync_overrun;

  bar_level_writer #(.SHIFT(SHIFT), .DECAY_FRAMES(DF)) dut (
    .clk(clk), .rst(rst), .mag_valid(mag_valid), .mag_ready(mag_ready),
    .mag_band(mag_band), .mag_data(mag_data), .frame_sync(frame_sync),
    .bars(bars), .frame_done(frame_done), .sync_overrun(sync_overrun)
  );

  always #5 clk = ~clk;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Model: levels per band, busy cycles left, commit scheduled for next edge
  int           wl [16];
  logic [287:0] exp_bars;
  bit           exp_fd;
  int           busy;
  bit           commit_now;
  int           ncommits;

  task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 16; n++) wl[n] = 0;
    exp_bars   = '0;
    exp_fd     = 1'b0;
    busy       = 0;
    commit_now = 1'b0;
    ncommits   = 0;
  endtask

  task automatic model_edge(input bit v, input int band, input int data, input bit fs);
    int lvl;
    exp_fd = 1'b0;
    if (commit_now) begin
      exp_bars = '0;
      for (int n = 0; n < 16; n++) exp_bars[18*n +: 18] = 18'((1 << wl[n]) - 1);
      exp_fd = 1'b1;
      if (ncommits % DF == DF - 1)
        for (int n = 0; n < 16; n++) if (wl[n] > 0) wl[n] = wl[n] - 1;
      ncommits++;
      commit_now = 1'b0;
    end
    if (busy == 0) begin
      if (v) begin
        lvl = data >> SHIFT;
        if (lvl > 18) lvl = 18;
        if (lvl > wl[band]) wl[band] = lvl;
      end
      if (fs) begin
        busy = 17;
        commit_now = 1'b1;
      end
    end else begin
      busy--;
    end
  endtask

  task automatic cycle(input bit v, input int band, input int data, input bit fs);
    @(negedge clk);
    mag_valid  = v;
    mag_band   = 4'(band);
    mag_data   = 16'(data);
    frame_sync = fs;
    #1;
    check("mag_ready", mag_ready, (busy == 0));
    check("sync_overrun", sync_overrun, (fs && busy != 0));
    check("frame_done", frame_done, exp_fd);
    check("bars", bars, exp_bars);
    model_edge(v, band, data, fs);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    mag_valid = 1'b0;
    frame_sync = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_bars", bars, 288'd0);
    check("rst_ready", mag_ready, 1'b1);
    check("rst_fd", frame_done, 1'b0);
    check("rst_ovr", sync_overrun, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    model_edge(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    logic [287:0] full3;
    int lv;
    model_reset();
    do_reset();

    // Band 3 saturates to 18
    cycle(1'b1, 3, 16'h9000, 1'b0);
    cycle(1'b0, 0, 0, 1'b1);
    idle(1);
    cycle(1'b0, 0, 0, 1'b0);
    full3 = '0;
    full3[71:54] = 18'h3FFFF;
    check("band3_full", bars, full3);
    check("band3_fd", frame_done, 1'b1);
    idle(17);

    // Peak hold then decay on every fourth commit
    do_reset();
    cycle(1'b1, 0, 16'h2800, 1'b0);
    cycle(1'b1, 0, 16'h1000, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      cycle(1'b0, 0, 0, 1'b1);
      idle(1);
      cycle(1'b0, 0, 0, 1'b0);
      lv = (k < 5) ? 5 : ((k < 9) ? 4 : 3);
      check("decay_band0", 288'(bars[17:0]), 288'((1 << lv) - 1));
      idle(16);
    end

    // Decay never goes below zero on an empty band
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 0, 0, 1'b1);
      idle(17);
    end

    // Overrun: second frame_sync at t+5, sample held with frame_sync
    cycle(1'b1, 7, 16'hFFFF, 1'b1);
    idle(4);
    cycle(1'b1, 8, 16'h4000, 1'b1);
    idle(14);

    // Reset in the middle of DECAY
    cycle(1'b1, 5, 16'h7000, 1'b0);
    cycle(1'b0, 0, 0, 1'b1);
    idle(6);
    do_reset();
    cycle(1'b1, 9, 16'h3000, 1'b0);
    cycle(1'b0, 0, 0, 1'b1);
    idle(18);

    // Randomised traffic
    for (int i = 0; i < 2500; i++) begin
      int d;
      case ($urandom_range(0, 3))
        0: d = 0;
        1: d = $urandom_range(0, 16'h2FFF);
        default: d = $urandom_range(0, 16'hFFFF);
      endcase
      cycle(($urandom_range(0, 1) == 1), $urandom_range(0, 15), d,
            ($urandom_range(0, 11) == 0));
      if (i == 1200) do_reset();
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
